frame_load_ctrl: RTL and testbench

Sequences UART bytes into 12-bit pixel writes for the image BRAM and arbitrates that memory's single port between the loader and the VGA read path. Sits between uart_rx, vga_display and image_memory in top, replacing the free-running write logic. Read (display) traffic has priority. Writes are buffered in a small FIFO and drained when the VGA is not reading, or forcibly after a starvation limit.

---
 rtl/frame_load_ctrl_pkg.sv | 23 ++
 rtl/frame_load_ctrl_if.sv | 27 ++
 rtl/frame_load_ctrl_wr_fifo.sv | 50 +++++
 rtl/frame_load_ctrl.sv | 152 +++++++++++++++
 tb/tb_frame_load_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_load_ctrl_pkg.sv
// Shared constants, state encoding and pixel packing for the frame loader.
package frame_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int PIX_W      = 12;
  localparam int ENTRY_W    = ADDR_W_DEF + PIX_W;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    RECV_HI,
    RECV_LO,
    DRAIN
  } load_state_t;

  // The high byte only carries red in its low nibble; the low byte is {G, B}.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [3:0] red,
                                                  input logic [7:0] green_blue);
    return {red, green_blue};
  endfunction

endpackage

// File: rtl/frame_load_ctrl_if.sv
// Byte input, VGA read request and BRAM port of the frame loader.
interface frame_load_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [11:0]       mem_wdata;
  logic              busy;
  logic              frame_done;
  logic              err_timeout;
  logic              err_overflow;

  // The controller masters the BRAM port; the surrounding system is the slave side.
  modport master (
    input  rx_data, rx_valid, rd_addr, rd_req,
    output mem_addr, mem_we, mem_wdata, busy, frame_done, err_timeout, err_overflow
  );

  modport slave (
    output rx_data, rx_valid, rd_addr, rd_req,
    input  mem_addr, mem_we, mem_wdata, busy, frame_done, err_timeout, err_overflow
  );
endinterface

// File: rtl/frame_load_ctrl_wr_fifo.sv
// Small synchronous FIFO buffering pixel writes; DEPTH must be a power of two >= 2.
module wr_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/frame_load_ctrl.sv
// Turns the UART byte stream into pixel writes and arbitrates the single BRAM
// port between those writes and the VGA reads, reads having priority.
module frame_load_ctrl
  import frame_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_PIXELS  = 76800,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int STEAL_CYC   = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input logic               clk,
  input logic               reset,
  frame_load_ctrl_if.master bus
);

  localparam int ENT_W  = ADDR_W + PIX_W;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int WAIT_W = $clog2(STEAL_CYC + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [WAIT_W-1:0] STEAL_LIM = WAIT_W'(STEAL_CYC);

  load_state_t       state;
  load_state_t       state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] wr_ptr_next;
  logic [3:0]        red;
  logic [3:0]        red_next;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;
  logic [WAIT_W-1:0] wait_cnt;

  logic              pixel_done;
  logic              timeout_hit;
  logic              grant_w;
  logic              push;
  logic              overflow;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  push_entry;
  logic [ENT_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [PIX_W-1:0]  head_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      red      <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      wr_ptr   <= wr_ptr_next;
      red      <= red_next;
      idle_cnt <= idle_next;
    end
  end

  // Inside a frame every byte is data, including SYNC_BYTE; only silence ends it early.
  always_comb begin
    state_next  = state;
    wr_ptr_next = wr_ptr;
    red_next    = red;
    idle_next   = idle_cnt;
    pixel_done  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          state_next  = RECV_HI;
          wr_ptr_next = '0;
          idle_next   = '0;
        end
      end
      RECV_HI, RECV_LO: begin
        if (bus.rx_valid) begin
          idle_next = '0;
          if (state == RECV_HI) begin
            red_next   = bus.rx_data[3:0];
            state_next = RECV_LO;
          end else begin
            pixel_done = 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              state_next = DRAIN;
            end else begin
              wr_ptr_next = wr_ptr + ADDR_W'(1);
              state_next  = RECV_HI;
            end
          end
        end else if (idle_cnt == LAST_IDLE) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
          wr_ptr_next = '0;
          idle_next   = '0;
        end else begin
          idle_next = idle_cnt + IDLE_W'(1);
        end
      end
      DRAIN: begin
        if (empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A dropped pixel still advances wr_ptr so later pixels keep their addresses.
  assign grant_w    = !empty && (!bus.rd_req || wait_cnt >= STEAL_LIM);
  assign push       = pixel_done && (!full || grant_w);
  assign overflow   = pixel_done && full && !grant_w;
  assign push_entry = {wr_ptr, pack_pixel(red, bus.rx_data)};
  assign head_addr  = head[ENT_W-1:PIX_W];
  assign head_data  = head[PIX_W-1:0];

  wr_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_wr_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(push_entry),
    .pop  (grant_w),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.frame_done   <= 1'b0;
      bus.err_timeout  <= 1'b0;
      bus.err_overflow <= 1'b0;
      wait_cnt         <= '0;
    end else begin
      bus.mem_we       <= grant_w;
      bus.mem_addr     <= grant_w ? head_addr : bus.rd_addr;
      if (grant_w) bus.mem_wdata <= head_data;
      bus.frame_done   <= grant_w && (head_addr == LAST_ADDR);
      bus.err_timeout  <= timeout_hit;
      bus.err_overflow <= overflow;
      wait_cnt         <= (empty || grant_w) ? '0 : wait_cnt + WAIT_W'(1);
    end
  end

  assign bus.busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Directed bench for frame_load_ctrl: a queue-level model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_frame_load_ctrl;
  import frame_pkg::*;

  localparam int AW    = 17;
  localparam int NPIX  = 6;
  localparam int TO    = 100;
  localparam int STEAL = 64;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  frame_load_ctrl_if #(.ADDR_W(AW)) bus ();

  frame_load_ctrl #(
    .ADDR_W(AW),
    .NUM_PIXELS(NPIX),
    .TIMEOUT_CYC(TO),
    .STEAL_CYC(STEAL),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: pending writes as a queue; frame progress as "what byte comes next".
  wr_t           mq[$];
  int            m_mode;   // 0 no frame, 1 want high byte, 2 want low byte, 3 frame complete
  int            m_pix;
  int            m_quiet;
  int            m_wait;
  logic [3:0]    m_red;
  logic          e_we, e_fd, e_to, e_ov;
  logic [AW-1:0] e_addr;
  logic [11:0]   e_data;

  logic [AW-1:0] log_addr[$];
  logic [11:0]   log_data[$];
  int            fd_cnt, to_cnt, ov_cnt;
  logic [AW-1:0] fd_addr;

  logic [11:0] exp_frame [NPIX] = '{12'hFFF, 12'h123, 12'h234, 12'h567, 12'h5A5, 12'hCDE};
  logic [7:0]  frame_bytes [2*NPIX] = '{8'h0F, 8'hFF, 8'h01, 8'h23, 8'hF2, 8'h34,
                                        8'h05, 8'h67, 8'hA5, 8'hA5, 8'h0C, 8'hDE};
  logic [11:0] exp_ovf [4] = '{12'h111, 12'h222, 12'h333, 12'h444};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_step();
    int  pre;
    bit  g;
    wr_t w;
    if (reset) begin
      mq.delete();
      m_mode = 0; m_pix = 0; m_quiet = 0; m_wait = 0; m_red = '0;
      e_we = 1'b0; e_fd = 1'b0; e_to = 1'b0; e_ov = 1'b0; e_addr = '0; e_data = '0;
    end else begin
      pre  = mq.size();
      g    = (pre != 0) && (!bus.rd_req || m_wait >= STEAL);
      e_we = g; e_fd = 1'b0; e_to = 1'b0; e_ov = 1'b0;
      if (g) begin
        w      = mq.pop_front();
        e_addr = w.addr;
        e_data = w.data;
        e_fd   = (w.addr == AW'(NPIX - 1));
      end else begin
        e_addr = bus.rd_addr;
      end
      m_wait = (pre == 0 || g) ? 0 : m_wait + 1;
      case (m_mode)
        0: if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
             m_mode = 1; m_pix = 0; m_quiet = 0;
           end
        1, 2: if (bus.rx_valid) begin
                m_quiet = 0;
                if (m_mode == 1) begin
                  m_red  = bus.rx_data[3:0];
                  m_mode = 2;
                end else begin
                  if (pre == DEPTH && !g) e_ov = 1'b1;
                  else mq.push_back('{addr: AW'(m_pix), data: {m_red, bus.rx_data}});
                  if (m_pix == NPIX - 1) m_mode = 3;
                  else begin m_pix++; m_mode = 1; end
                end
              end else begin
                m_quiet++;
                if (m_quiet == TO) begin
                  e_to = 1'b1; m_mode = 0; m_pix = 0; m_quiet = 0;
                end
              end
        default: if (pre == 0) m_mode = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_output("mem_we", bus.mem_we, e_we);
      check_output("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check_output("mem_wdata", bus.mem_wdata, e_data);
      check_output("frame_done", bus.frame_done, e_fd);
      check_output("err_timeout", bus.err_timeout, e_to);
      check_output("err_overflow", bus.err_overflow, e_ov);
      check_output("busy", bus.busy, (m_mode != 0) || (mq.size() != 0));
      if (bus.mem_we) begin
        log_addr.push_back(bus.mem_addr);
        log_data.push_back(bus.mem_wdata);
      end
      if (bus.frame_done) begin fd_cnt++; fd_addr = bus.mem_addr; end
      if (bus.err_timeout) to_cnt++;
      if (bus.err_overflow) ov_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic clear_logs();
    log_addr.delete();
    log_data.delete();
    fd_cnt = 0; to_cnt = 0; ov_cnt = 0; fd_addr = '0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check_output({tag, "_idle"}, bus.busy, 0);
    repeat (3) tick();
  endtask

  task automatic check_single(input string tag, input logic [11:0] data);
    check_output({tag, "_count"}, log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      check_output({tag, "_addr"}, log_addr[0], 0);
      check_output({tag, "_data"}, log_data[0], data);
    end
  endtask

  initial begin
    bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    fd_cnt = 0; to_cnt = 0; ov_cnt = 0; fd_addr = '0;
    repeat (3) tick();
    chk_en = 1'b1;
    check_output("rst_mem_we", bus.mem_we, 0);
    check_output("rst_mem_addr", bus.mem_addr, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_flags", {bus.frame_done, bus.err_timeout, bus.err_overflow}, 0);
    reset = 1'b0;
    tick();

    $display("[TB] idle load of a full frame");
    clear_logs();
    apply_stimulus(SYNC_BYTE);
    for (int i = 0; i < 2 * NPIX; i++) apply_stimulus(frame_bytes[i]);
    wait_idle(50, "load");
    check_output("load_count", log_addr.size(), NPIX);
    for (int i = 0; i < NPIX && i < log_addr.size(); i++) begin
      check_output("load_addr", log_addr[i], i);
      check_output("load_data", log_data[i], exp_frame[i]);
    end
    check_output("load_done_cnt", fd_cnt, 1);
    check_output("load_done_addr", fd_addr, NPIX - 1);

    $display("[TB] read priority and slot stealing");
    bus.rd_req = 1'b1;
    bus.rd_addr = 17'h1234;
    tick();
    check_output("rd_follow_a", bus.mem_addr, 17'h1234);
    bus.rd_addr = 17'h0ABC;
    tick();
    check_output("rd_follow_b", bus.mem_addr, 17'h0ABC);
    clear_logs();
    apply_stimulus(SYNC_BYTE);
    apply_stimulus(8'h01);
    apply_stimulus(8'h23);
    for (int i = 0; i < 90; i++) begin
      bus.rd_addr = AW'(100 + i);
      tick();
    end
    check_single("steal", 12'h123);
    wait_idle(200, "steal");
    bus.rd_req = 1'b0;

    $display("[TB] garbage before sync");
    clear_logs();
    apply_stimulus(8'h00);
    apply_stimulus(8'hFF);
    apply_stimulus(8'hA6);
    apply_stimulus(SYNC_BYTE);
    apply_stimulus(8'h03);
    apply_stimulus(8'h45);
    wait_idle(300, "garbage");
    check_single("garbage", 12'h345);
    check_output("garbage_to_cnt", to_cnt, 1);

    $display("[TB] inter-byte timeout");
    clear_logs();
    apply_stimulus(SYNC_BYTE);
    apply_stimulus(8'h0F);
    wait_idle(300, "timeout");
    check_output("timeout_cnt", to_cnt, 1);
    check_output("timeout_writes", log_addr.size(), 0);
    clear_logs();
    apply_stimulus(SYNC_BYTE);
    apply_stimulus(8'h01);
    apply_stimulus(8'h23);
    wait_idle(300, "restart");
    check_single("restart", 12'h123);

    $display("[TB] FIFO overflow under read pressure");
    clear_logs();
    bus.rd_req = 1'b1;
    apply_stimulus(SYNC_BYTE);
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(8'(i));
      apply_stimulus(8'(i * 17));
    end
    check_output("ovf_pulse_cnt", ov_cnt, 1);
    check_output("ovf_no_write_yet", log_addr.size(), 0);
    bus.rd_req = 1'b0;
    wait_idle(300, "ovf");
    check_output("ovf_count", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check_output("ovf_addr", log_addr[i], i);
      check_output("ovf_data", log_data[i], exp_ovf[i]);
    end

    $display("[TB] reset mid-frame");
    clear_logs();
    bus.rd_req = 1'b1;
    apply_stimulus(SYNC_BYTE);
    apply_stimulus(8'h0A); apply_stimulus(8'hBC);
    apply_stimulus(8'h0D); apply_stimulus(8'hEF);
    apply_stimulus(8'h01); apply_stimulus(8'h02);
    check_output("pre_rst_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    check_output("mid_rst_we", bus.mem_we, 0);
    check_output("mid_rst_busy", bus.busy, 0);
    reset = 1'b0;
    bus.rd_req = 1'b0;
    repeat (10) tick();
    check_output("mid_rst_stale", log_addr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
